// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the accumulator ALU.
//   ALU_OP_W     : opcode width
//   alu_op_e     : opcode encoding driven on alu_accum_seq.op
//   alu_state_e  : control FSM states (IDLE, BUSY, DONE)
//   is_muldiv()  : true for the opcodes served by the iterative engine
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SHL  = 4'd2,
    OP_SHR  = 4'd3,
    OP_ROL  = 4'd4,
    OP_ROR  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_NOR  = 4'd9,
    OP_NAND = 4'd10,
    OP_XNOR = 4'd11,
    OP_GT   = 4'd12,
    OP_EQ   = 4'd13,
    OP_MUL  = 4'd14,
    OP_DIV  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  function automatic logic is_muldiv(input alu_op_e f);
    return (f == OP_MUL) || (f == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter -- iterative shift-add multiplier / restoring divider.
// Only compiled when ALU_MULDIV_EN is defined.
//   clk, rst  : clock, synchronous active-high reset (aborts an operation)
//   start     : load operands a, b and the is_div select; W steps follow
//   done      : high in the cycle whose clock edge performs the final step
//   result    : value after the current step; valid when done is high
//               MUL: {product}   DIV: {remainder, quotient}
//   div_zero  : DIV with a zero divisor (quotient all-ones, remainder a)
`ifdef ALU_MULDIV_EN
module alu_muldiv_iter #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           is_div,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           div_zero
);

  localparam int CW = $clog2(W + 1);

  // hi holds the partial product high half / partial remainder,
  // lo holds the multiplier being shifted out / dividend shifting into quotient.
  logic [W-1:0]  hi_q, hi_d, hi_step;
  logic [W-1:0]  lo_q, lo_d, lo_step;
  logic [W-1:0]  d_q, d_d;
  logic          is_div_q, is_div_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    sum;
  logic [W:0]    shifted;
  logic          ge;

  // One step of either algorithm, plus operand load and step counting.
  always_comb begin
    sum     = {1'b0, hi_q} + {1'b0, {W{lo_q[0]}} & d_q};
    shifted = {hi_q, lo_q[W-1]};
    ge      = shifted >= {1'b0, d_q};
    if (is_div_q) begin
      // A zero divisor always subtracts successfully, which naturally gives
      // an all-ones quotient and leaves the dividend as the remainder.
      hi_step = ge ? W'(shifted - {1'b0, d_q}) : W'(shifted);
      lo_step = {lo_q[W-2:0], ge};
    end else begin
      hi_step = sum[W:1];
      lo_step = {sum[0], lo_q[W-1:1]};
    end

    hi_d     = hi_q;
    lo_d     = lo_q;
    d_d      = d_q;
    is_div_d = is_div_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    if (start) begin
      hi_d     = '0;
      lo_d     = a;
      d_d      = b;
      is_div_d = is_div;
      busy_d   = 1'b1;
      cnt_d    = CW'(W);
    end else if (busy_q) begin
      hi_d  = hi_step;
      lo_d  = lo_step;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  // Engine state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      d_q      <= '0;
      is_div_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      d_q      <= d_d;
      is_div_q <= is_div_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign done     = busy_q && (cnt_q == CW'(1));
  assign result   = {hi_step, lo_step};
  assign div_zero = is_div_q && (d_q == '0);

endmodule
`endif

// File: rtl/alu_accum_seq.sv
// alu_accum_seq -- sequential ALU with an accumulator and valid/ready handshakes.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : command handshake (in_ready high only in IDLE)
//   op, a, b            : opcode (alu_pkg::alu_op_e) and operands
//   use_acc             : use the accumulator in place of a
//   acc_wr              : write result[W-1:0] to acc when the result is taken
//   out_valid/out_ready : result handshake
//   result, carry, zero, err : result (2W bits) and flags
//   acc                 : accumulator value
// Macro ALU_MULDIV_EN: when defined, MUL/DIV use the W-cycle alu_muldiv_iter
// engine; otherwise they finish in one cycle with result 0 and err set.
module alu_accum_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  input  logic                use_acc,
  input  logic                acc_wr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*W-1:0]      result,
  output logic                carry,
  output logic                zero,
  output logic                err,
  output logic [W-1:0]        acc
);

  alu_state_e     state_q, state_d;
  logic [2*W-1:0] result_q, result_d;
  logic           carry_q, carry_d;
  logic           zero_q, zero_d;
  logic           err_q, err_d;
  logic [W-1:0]   acc_q, acc_d;
  logic           acc_wr_q, acc_wr_d;
  logic [W-1:0]   eff_a;
  logic [W:0]     single;
  alu_op_e        op_e;
  logic           accept;

`ifdef ALU_MULDIV_EN
  logic           md_start;
  logic           md_done;
  logic [2*W-1:0] md_result;
  logic           md_div_zero;

  alu_muldiv_iter #(.W(W)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start    (md_start),
    .is_div   (op_e == OP_DIV),
    .a        (eff_a),
    .b        (b),
    .done     (md_done),
    .result   (md_result),
    .div_zero (md_div_zero)
  );
`endif

  // Single-cycle operations; bit W is carry (ADD) or borrow (SUB).
  function automatic logic [W:0] alu_single(input alu_op_e f, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    logic [W:0] r;
    r = '0;
    case (f)
      OP_ADD:  r = {1'b0, x} + {1'b0, y};
      OP_SUB:  r = {1'b0, x} - {1'b0, y};
      OP_SHL:  r = {1'b0, x[W-2:0], 1'b0};
      OP_SHR:  r = {2'b00, x[W-1:1]};
      OP_ROL:  r = {1'b0, x[W-2:0], x[W-1]};
      OP_ROR:  r = {1'b0, x[0], x[W-1:1]};
      OP_AND:  r = {1'b0, x & y};
      OP_OR:   r = {1'b0, x | y};
      OP_XOR:  r = {1'b0, x ^ y};
      OP_NOR:  r = {1'b0, ~(x | y)};
      OP_NAND: r = {1'b0, ~(x & y)};
      OP_XNOR: r = {1'b0, ~(x ^ y)};
      OP_GT:   r = {{W{1'b0}}, x > y};
      OP_EQ:   r = {{W{1'b0}}, x == y};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign op_e     = alu_op_e'(op);
  assign eff_a    = use_acc ? acc_q : a;
  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign single   = alu_single(op_e, eff_a, b);

  // Next-state and datapath capture. Single-cycle results are registered
  // directly at acceptance so they appear on the following cycle.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;
    acc_d    = acc_q;
    acc_wr_d = acc_wr_q;
`ifdef ALU_MULDIV_EN
    md_start = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_wr_d = acc_wr;
          if (is_muldiv(op_e)) begin
`ifdef ALU_MULDIV_EN
            md_start = 1'b1;
            state_d  = BUSY;
`else
            result_d = '0;
            carry_d  = 1'b0;
            zero_d   = 1'b1;
            err_d    = 1'b1;
            acc_wr_d = 1'b0;
            state_d  = DONE;
`endif
          end else begin
            result_d = {{W{1'b0}}, single[W-1:0]};
            carry_d  = single[W];
            zero_d   = (single[W-1:0] == '0);
            err_d    = 1'b0;
            state_d  = DONE;
          end
        end
      end
      BUSY: begin
`ifdef ALU_MULDIV_EN
        if (md_done) begin
          result_d = md_result;
          carry_d  = 1'b0;
          zero_d   = (md_result == '0);
          err_d    = md_div_zero;
          state_d  = DONE;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          if (acc_wr_q) begin
            acc_d = result_q[W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      acc_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      acc_wr_q <= acc_wr_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign err       = err_q;
  assign acc       = acc_q;

endmodule

// File: doc/alu_accum_seq.md
ALU_ACCUM_SEQ -- requirements
Module: alu_accum_seq

Interface
REQ-001 SHALL have parameter W, default 8, meaning operand and accumulator width (W >= 4).
REQ-002 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit, reset: synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1 bit, command offered.
REQ-005 SHALL have port in_ready, output, 1 bit, command accepted this cycle if in_valid is high.
REQ-006 SHALL have port op, input, 4 bits, opcode (encoding in package).
REQ-007 SHALL have port a, input, W bits, operand A.
REQ-008 SHALL have port b, input, W bits, operand B.
REQ-009 SHALL have port use_acc, input, 1 bit, substitute the accumulator for A.
REQ-010 SHALL have port acc_wr, input, 1 bit, write result[W-1:0] to the accumulator on completion.
REQ-011 SHALL have port out_valid, output, 1 bit, result available.
REQ-012 SHALL have port out_ready, input, 1 bit, consumer takes the result.
REQ-013 SHALL have port result, output, 2W bits, operation result.
REQ-014 SHALL have port carry, output, 1 bit, carry out, or borrow on SUB.
REQ-015 SHALL have port zero, output, 1 bit, result equals 0.
REQ-016 SHALL have port err, output, 1 bit, divide-by-zero or unsupported op.
REQ-017 SHALL have port acc, output, W bits, current accumulator value.

Function
REQ-018 SHALL use FSM states IDLE, BUSY, DONE; in_ready is high only in IDLE.
REQ-019 SHALL, on in_valid&&in_ready, capture op, effective A, b and acc_wr into registers.
REQ-020 SHALL complete ADD, SUB, SHL, SHR, ROL, ROR, AND, OR, XOR, NOR, NAND, XNOR, GT and EQ in one cycle: IDLE->DONE, out_valid high on the cycle after acceptance.
REQ-021 SHALL zero-extend every single-cycle result to 2W bits: ADD/SUB modulo 2^W with carry/borrow on carry; shifts and rotates by 1 within W bits; GT/EQ unsigned, returning 1 or 0.
REQ-022 SHALL compute MUL and DIV iteratively: IDLE->BUSY for exactly W cycles, then DONE; out_valid asserts W+1 cycles after acceptance.
REQ-023 SHALL return the full unsigned 2W-bit product for MUL, and quotient in result[W-1:0] with remainder in result[2W-1:W] for DIV.
REQ-024 SHALL, on DIV with B=0, return quotient all-ones and remainder A, set err, and still take W cycles.
REQ-025 SHALL hold result, carry, zero and err stable in DONE until out_valid&&out_ready, then enter IDLE; in_ready rises the following cycle.
REQ-026 SHALL update acc with result[W-1:0] in the handshake cycle of REQ-025 only if acc_wr was captured high; the new value is visible from the next cycle.
REQ-027 SHALL, when use_acc is high, read acc as it stood at acceptance, so a dependent command issued immediately sees the prior write.
REQ-028 SHALL ignore in_valid, op, a and b outside IDLE.

Reset
REQ-029 SHALL, when rst is high at a clock edge, enter IDLE and clear acc, result, carry, zero, err and out_valid to 0, aborting any BUSY operation without writing acc.
REQ-030 SHALL hold in_ready low while rst is high.

Configuration
REQ-031 SHALL implement the MUL/DIV engine only when ALU_MULDIV_EN is defined.
REQ-032 SHALL, when ALU_MULDIV_EN is undefined, complete MUL and DIV in one cycle with result 0, err 1 and acc untouched, and contain no multiplier/divider logic.

Structure
REQ-033 SHALL take the opcode enum, FSM state typedef and ALU_OP_W=4 from shared package alu_pkg.
REQ-034 SHALL place the iterative shift-add multiplier and restoring divider in sub-module alu_muldiv_iter (start, done, W-cycle latency).

Verification (W=8)
REQ-035 SHALL check ADD a=200 b=100: result=44, carry=1, out_valid one cycle after accept.
REQ-036 SHALL check MUL a=255 b=255: result=65025, out_valid 9 cycles after accept; with the macro undefined, result=0 and err=1 after 1 cycle.
REQ-037 SHALL check DIV a=100 b=7 -> quotient 14, remainder 2; DIV b=0 a=5 -> quotient 255, remainder 5, err=1.
REQ-038 SHALL check ADD a=3 b=4 acc_wr=1, then ADD use_acc=1 b=1 acc_wr=1: result=8, acc=8.
REQ-039 SHALL check out_ready held low 5 cycles: result stable, in_ready low, new in_valid ignored.
REQ-040 SHALL check rst asserted in BUSY cycle 4 of DIV: next cycle IDLE, acc=0, out_valid=0, no result emitted.
